// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
// Optional misaligned-redirect checking in pc_gen is enabled by PC_GEN_MISALIGN_CHK_EN.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } pc_state_e;

    localparam logic [31:0] PC_DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] PC_DEF_EXC_VEC   = 32'h0000_0180;

    // INSN_BYTES is a power of two, so the low-bit mask is simply INSN_BYTES-1.
    function automatic logic [63:0] align_mask(input int unsigned insn_bytes);
        return 64'(insn_bytes) - 64'd1;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Instruction-fetch request/acknowledge bus between pc_gen and instruction memory.
interface pc_gen_if #(
    parameter int ADDR_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ack;

    modport master (output fetch_req, output fetch_addr, input fetch_ack);
    modport slave  (input fetch_req, input fetch_addr, output fetch_ack);
endinterface

// File: rtl/pc_gen_next_sel.sv
// Next-PC selector: exception > redirect > pending target > increment > hold.
module pc_next_sel #(
    parameter int          ADDR_W     = 32,
    parameter int unsigned INSN_BYTES = 4,
    parameter logic [31:0] EXC_VEC    = 32'h0000_0180
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              exc_i,
    input  logic              redir_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic              pend_v_i,
    input  logic [ADDR_W-1:0] pend_tgt_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] next_pc_o
);
    localparam logic [ADDR_W-1:0] EXC_PC = ADDR_W'(EXC_VEC);
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(INSN_BYTES);

    always_comb begin
        next_pc_o = pc_i;
        if (exc_i) begin
            next_pc_o = EXC_PC;
        end else if (redir_i) begin
            next_pc_o = target_i;
        end else if (pend_v_i) begin
            next_pc_o = pend_tgt_i;
        end else if (adv_i) begin
            next_pc_o = pc_i + STEP;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator issuing req/ack fetches with stall, redirect and exception handling.
// Define PC_GEN_MISALIGN_CHK_EN to turn misaligned redirect targets into exceptions.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int unsigned INSN_BYTES = 4,
    parameter logic [31:0] RESET_VEC  = PC_DEF_RESET_VEC,
    parameter logic [31:0] EXC_VEC    = PC_DEF_EXC_VEC
) (
    input  logic              pc_clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              redir_valid_i,
    input  logic [ADDR_W-1:0] redir_target_i,
    input  logic              exc_valid_i,
    pc_gen_if.master          fetch,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] link_o,
    output logic              misalign_o
);
    localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(EXC_VEC);
    localparam logic [ADDR_W-1:0] ALIGN_M  = ADDR_W'(align_mask(INSN_BYTES));
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INSN_BYTES);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_v_q, pend_v_d;
    logic              pend_exc_q, pend_exc_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              req_q, req_d;

    logic              eff_exc;
    logic              eff_redir;
    logic [ADDR_W-1:0] eff_target;
    logic              in_req;
    logic              ack;
    logic [ADDR_W-1:0] sel_pc;

`ifdef PC_GEN_MISALIGN_CHK_EN
    logic mis;
    assign mis        = redir_valid_i & (|(redir_target_i & ALIGN_M));
    assign eff_exc    = exc_valid_i | mis;
    assign eff_redir  = redir_valid_i & ~mis;
    assign eff_target = redir_target_i;
    assign misalign_o = rst_n & mis;
`else
    assign eff_exc    = exc_valid_i;
    assign eff_redir  = redir_valid_i;
    assign eff_target = redir_target_i & ~ALIGN_M;
    assign misalign_o = 1'b0;
`endif

    assign in_req = (state_q == REQ);
    assign ack    = in_req & fetch.fetch_ack;

    // Pending target only exists while a request is outstanding, so gate it to REQ.
    pc_next_sel #(
        .ADDR_W     (ADDR_W),
        .INSN_BYTES (INSN_BYTES),
        .EXC_VEC    (EXC_VEC)
    ) u_next_sel (
        .pc_i       (pc_q),
        .exc_i      (eff_exc),
        .redir_i    (eff_redir),
        .target_i   (eff_target),
        .pend_v_i   (pend_v_q & in_req),
        .pend_tgt_i (pend_tgt_q),
        .adv_i      (in_req),
        .next_pc_o  (sel_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_v_d   = pend_v_q;
        pend_exc_d = pend_exc_q;
        pend_tgt_d = pend_tgt_q;
        unique case (state_q)
            BOOT, HOLD: begin
                pc_d    = sel_pc;
                state_d = stall_i ? HOLD : REQ;
            end
            REQ: begin
                if (ack) begin
                    pc_d       = sel_pc;
                    pend_v_d   = 1'b0;
                    pend_exc_d = 1'b0;
                    state_d    = stall_i ? HOLD : REQ;
                end else if (eff_exc) begin
                    pend_tgt_d = EXC_PC;
                    pend_exc_d = 1'b1;
                    pend_v_d   = 1'b1;
                end else if (eff_redir && !pend_exc_q) begin
                    // A later redirect replaces an earlier one; a pending exception is sticky.
                    pend_tgt_d = eff_target;
                    pend_v_d   = 1'b1;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        req_d = (state_d == REQ);
    end

    always_ff @(posedge pc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pend_v_q   <= 1'b0;
            pend_exc_q <= 1'b0;
            pend_tgt_q <= '0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_v_q   <= pend_v_d;
            pend_exc_q <= pend_exc_d;
            pend_tgt_q <= pend_tgt_d;
            req_q      <= req_d;
        end
    end

    assign fetch.fetch_req  = req_q;
    assign fetch.fetch_addr = pc_q;
    assign pc_o             = pc_q;
    assign link_o           = pc_q + STEP;

endmodule

// File: tb/tb_pc_gen.sv
// Directed table-driven bench for pc_gen plus a wrap-around instance and an async-reset sequence.
module tb_pc_gen;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        exc;
        logic        ack;
        logic        req;
        logic [31:0] addr;
        logic        mis;
    } vec_t;

`ifdef PC_GEN_MISALIGN_CHK_EN
    localparam logic [31:0] MIS_PC  = 32'h0000_0180;
    localparam logic        MIS_EXP = 1'b1;
`else
    localparam logic [31:0] MIS_PC  = 32'h0000_0100;
    localparam logic        MIS_EXP = 1'b0;
`endif

    localparam int NV = 34;

    logic        pc_clk = 1'b0;
    logic        rst_n  = 1'b1;
    logic        stall_i, redir_valid_i, exc_valid_i;
    logic [31:0] redir_target_i;
    logic [31:0] pc_o, link_o, w_pc, w_link;
    logic        misalign_o, w_mis;

    int n_run  = 0;
    int n_fail = 0;

    vec_t vecs [NV];

    always #5 pc_clk = ~pc_clk;

    pc_gen_if #(.ADDR_W(32)) bus ();
    pc_gen_if #(.ADDR_W(32)) wbus ();

    pc_gen #(.ADDR_W(32), .INSN_BYTES(4)) dut (
        .pc_clk         (pc_clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .redir_valid_i  (redir_valid_i),
        .redir_target_i (redir_target_i),
        .exc_valid_i    (exc_valid_i),
        .fetch          (bus),
        .pc_o           (pc_o),
        .link_o         (link_o),
        .misalign_o     (misalign_o)
    );

    pc_gen #(.ADDR_W(32), .INSN_BYTES(4), .RESET_VEC(32'hFFFF_FFFC)) u_wrap (
        .pc_clk         (pc_clk),
        .rst_n          (rst_n),
        .stall_i        (1'b0),
        .redir_valid_i  (1'b0),
        .redir_target_i (32'h0),
        .exc_valid_i    (1'b0),
        .fetch          (wbus),
        .pc_o           (w_pc),
        .link_o         (w_link),
        .misalign_o     (w_mis)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t, input logic e,
                                input logic a, input logic q, input logic [31:0] ad, input logic m);
        vec_t v;
        v.stall = s; v.redir = r; v.tgt = t; v.exc = e; v.ack = a;
        v.req = q; v.addr = ad; v.mis = m;
        return v;
    endfunction

    initial begin
        // stall redir target exc ack | req addr misalign
        vecs[0]  = mk(0, 0, 32'h0,   0, 1, 0, 32'h00,  0); // BOOT, ack ignored
        vecs[1]  = mk(0, 0, 32'h0,   0, 1, 1, 32'h00,  0);
        vecs[2]  = mk(0, 0, 32'h0,   0, 1, 1, 32'h04,  0);
        vecs[3]  = mk(0, 0, 32'h0,   0, 1, 1, 32'h08,  0);
        vecs[4]  = mk(0, 0, 32'h0,   0, 1, 1, 32'h0C,  0);
        vecs[5]  = mk(0, 0, 32'h0,   0, 0, 1, 32'h10,  0); // slow memory
        vecs[6]  = mk(0, 0, 32'h0,   0, 0, 1, 32'h10,  0);
        vecs[7]  = mk(0, 0, 32'h0,   0, 0, 1, 32'h10,  0);
        vecs[8]  = mk(0, 0, 32'h0,   0, 1, 1, 32'h10,  0);
        vecs[9]  = mk(0, 0, 32'h0,   0, 1, 1, 32'h14,  0);
        vecs[10] = mk(0, 0, 32'h0,   0, 1, 1, 32'h18,  0);
        vecs[11] = mk(0, 0, 32'h0,   0, 1, 1, 32'h1C,  0);
        vecs[12] = mk(0, 1, 32'h100, 0, 0, 1, 32'h20,  0); // redir pending
        vecs[13] = mk(0, 0, 32'h0,   1, 0, 1, 32'h20,  0); // exc overrides
        vecs[14] = mk(0, 1, 32'h200, 0, 0, 1, 32'h20,  0); // ignored
        vecs[15] = mk(0, 0, 32'h0,   0, 1, 1, 32'h20,  0);
        vecs[16] = mk(0, 0, 32'h0,   0, 1, 1, 32'h180, 0);
        vecs[17] = mk(0, 1, 32'h40,  0, 1, 1, 32'h184, 0); // redir with ack
        vecs[18] = mk(1, 0, 32'h0,   0, 1, 1, 32'h40,  0); // stall on ack
        vecs[19] = mk(1, 1, 32'h80,  0, 0, 0, 32'h44,  0); // redir in HOLD
        vecs[20] = mk(0, 0, 32'h0,   0, 1, 0, 32'h80,  0);
        vecs[21] = mk(0, 0, 32'h0,   0, 1, 1, 32'h80,  0);
        vecs[22] = mk(0, 1, 32'h300, 0, 0, 1, 32'h84,  0);
        vecs[23] = mk(0, 0, 32'h0,   0, 1, 1, 32'h84,  0); // pend used
        vecs[24] = mk(0, 1, 32'h500, 1, 1, 1, 32'h300, 0); // exc beats redir
        vecs[25] = mk(0, 1, 32'h400, 0, 0, 1, 32'h180, 0);
        vecs[26] = mk(0, 1, 32'h404, 0, 0, 1, 32'h180, 0); // overwrite
        vecs[27] = mk(0, 0, 32'h0,   0, 1, 1, 32'h180, 0);
        vecs[28] = mk(1, 0, 32'h0,   0, 1, 1, 32'h404, 0);
        vecs[29] = mk(1, 1, 32'h102, 0, 0, 0, 32'h408, MIS_EXP);
        vecs[30] = mk(0, 0, 32'h0,   0, 0, 0, MIS_PC,  0);
        vecs[31] = mk(1, 0, 32'h0,   0, 0, 1, MIS_PC,  0); // stall ignored mid-request
        vecs[32] = mk(0, 0, 32'h0,   0, 1, 1, MIS_PC,  0);
        vecs[33] = mk(0, 0, 32'h0,   0, 1, 1, MIS_PC + 32'h4, 0);

        stall_i = 1'b0; redir_valid_i = 1'b0; exc_valid_i = 1'b0;
        redir_target_i = 32'h0; bus.fetch_ack = 1'b0; wbus.fetch_ack = 1'b1;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge pc_clk);
        #1;
        chk("rst_req",  {31'h0, bus.fetch_req}, 32'h0);
        chk("rst_addr", bus.fetch_addr, 32'h0);
        chk("rst_pc",   pc_o, 32'h0);
        chk("rst_link", link_o, 32'h4);
        chk("rst_mis",  {31'h0, misalign_o}, 32'h0);
        chk("rst_wrap", w_pc, 32'hFFFF_FFFC);
        @(negedge pc_clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            stall_i        = vecs[i].stall;
            redir_valid_i  = vecs[i].redir;
            redir_target_i = vecs[i].tgt;
            exc_valid_i    = vecs[i].exc;
            bus.fetch_ack  = vecs[i].ack;
            #1;
            chk($sformatf("v%0d_req", i),  {31'h0, bus.fetch_req}, {31'h0, vecs[i].req});
            chk($sformatf("v%0d_addr", i), bus.fetch_addr, vecs[i].addr);
            chk($sformatf("v%0d_link", i), link_o, vecs[i].addr + 32'h4);
            chk($sformatf("v%0d_mis", i),  {31'h0, misalign_o}, {31'h0, vecs[i].mis});
            @(negedge pc_clk);
        end

        // Async reset while a redirect is pending on an outstanding request.
        redir_valid_i = 1'b1; redir_target_i = 32'h700; bus.fetch_ack = 1'b0;
        @(posedge pc_clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req",   {31'h0, bus.fetch_req}, 32'h0);
        chk("ar_addr",  bus.fetch_addr, 32'h0);
        chk("ar_wreq",  {31'h0, wbus.fetch_req}, 32'h0);
        chk("ar_waddr", w_pc, 32'hFFFF_FFFC);
        @(negedge pc_clk);
        rst_n = 1'b1; redir_valid_i = 1'b0; bus.fetch_ack = 1'b1;
        #1;
        chk("boot_req",  {31'h0, bus.fetch_req}, 32'h0);
        chk("boot_wreq", {31'h0, wbus.fetch_req}, 32'h0);
        @(negedge pc_clk);
        #1;
        chk("r1_req",   {31'h0, bus.fetch_req}, 32'h1);
        chk("r1_addr",  bus.fetch_addr, 32'h0);
        chk("w1_req",   {31'h0, wbus.fetch_req}, 32'h1);
        chk("w1_addr",  wbus.fetch_addr, 32'hFFFF_FFFC);
        chk("w1_link",  w_link, 32'h0);
        @(negedge pc_clk);
        #1;
        chk("r2_addr",  bus.fetch_addr, 32'h4);
        chk("w2_addr",  wbus.fetch_addr, 32'h0);
        chk("w2_link",  w_link, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator; successor to the plain PC register.
- Holds the PC and issues req/ack fetch requests to instruction memory.
- Handles stall, branch/jump redirect and exception vectoring, with next-PC priority resolved internally.
- Sits between decode/execute (redirect and stall sources) and the instruction-fetch port.

Parameters:
- ADDR_W, 32, PC/address width in bits.
- INSN_BYTES, 4, sequential increment; power of two, ≥1.
- RESET_VEC, 32'h0000_0000, PC value on reset; truncated to ADDR_W.
- EXC_VEC, 32'h0000_0180, exception entry address; truncated to ADDR_W.

Ports:
- pc_clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- stall_i  input  1  level; 1 = do not issue new fetch requests.
- redir_valid_i  input  1  one-cycle pulse; branch/jump taken.
- redir_target_i  input  ADDR_W  redirect target, sampled when redir_valid_i=1.
- exc_valid_i  input  1  one-cycle pulse; vector to EXC_VEC.
- fetch_req_o  output  1  fetch request valid.
- fetch_addr_o  output  ADDR_W  fetch address; equals pc_o.
- fetch_ack_i  input  1  memory accepts request this cycle.
- pc_o  output  ADDR_W  current PC register.
- link_o  output  ADDR_W  pc_o + INSN_BYTES, modulo 2^ADDR_W; combinational.
- misalign_o  output  1  misaligned-redirect pulse (see Optional Feature).

Behaviour:
- Reset (rst_n=0, async):
  - pc=RESET_VEC, state=BOOT, pend_v=0, pend_exc=0, misalign_o=0.
  - Consequently fetch_req_o=0, pc_o=fetch_addr_o=RESET_VEC.
- Arithmetic: all PC sums are modulo 2^ADDR_W; 0xFFFF_FFFC+4 wraps to 0.
- Event priority, same cycle: exc_valid_i > redir_valid_i > pending target > increment.
- States:
  - BOOT:
    - fetch_req_o=0.
    - exc/redir loads pc directly.
    - Next state: HOLD if stall_i=1, else REQ.
    - Lasts exactly one cycle after reset release.
  - REQ:
    - fetch_req_o=1.
    - fetch_addr_o stable while waiting for ack; never changes mid-request.
    - Ack this cycle, pc load priority:
      - exc → pc=EXC_VEC.
      - else redir → pc=redir_target_i.
      - else pend_v → pc=pend target.
      - else pc=pc+INSN_BYTES.
    - On ack: pend_v←0; next state HOLD if stall_i=1, else REQ (back-to-back requests, one per cycle).
    - No ack this cycle:
      - exc → pend target=EXC_VEC, pend_exc=1, pend_v=1.
      - redir with pend_exc=0 → pend target=redir_target_i, pend_v=1; a later redirect overwrites an earlier one.
      - redir with pend_exc=1 → ignored.
      - pc unchanged.
  - HOLD:
    - fetch_req_o=0.
    - exc/redir loads pc directly; pend never used (no outstanding request).
    - Exit to REQ the cycle after stall_i=0.
- Latency:
  - Redirect in HOLD/BOOT: visible on fetch_addr_o next cycle.
  - Redirect in REQ without ack: applied at the cycle after the ack.
- stall_i is ignored for an outstanding request; a request is never withdrawn.
- fetch_ack_i outside REQ is ignored.
- Async reset mid-request drops the request immediately; no pend state survives.

Optional Feature:
- Macro: PC_GEN_MISALIGN_CHK_EN.
- Defined:
  - A redirect target with any of the low log2(INSN_BYTES) bits set is treated as exc_valid_i.
  - misalign_o pulses 1 for one cycle in the cycle the target is sampled.
- Undefined:
  - Low log2(INSN_BYTES) bits of redir_target_i are forced to 0.
  - misalign_o is constant 0.

Decomposition:
- Shared package pc_gen_pkg:
  - State enum {BOOT, REQ, HOLD}, 2-bit encoding.
  - Default vector constants.
  - Function computing the alignment mask from INSN_BYTES.
- One combinational sub-module, pc_next_sel:
  - Inputs: pc, exc, redir, target, pend fields.
  - Output: next-PC value per the priority list.
- The FSM and registers stay in pc_gen.

Test Plan:
- Reset → sequential run: release rst_n, stall_i=0, ack every cycle.
  - fetch_req_o=0 for one cycle, then fetch_addr_o = 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- Slow memory: hold ack low 3 cycles at pc=0x10.
  - fetch_addr_o stays 0x10, fetch_req_o stays 1.
  - After ack, next address is 0x14.
- Redirect and exception while waiting:
  - At pc=0x20, no ack: redir to 0x100, then exc the next cycle, then redir to 0x200.
  - After ack, fetch_addr_o=0x180 (pending exception not overwritten).
- Stall and HOLD redirect:
  - stall_i=1 with ack at 0x40 → fetch_req_o=0 next cycle.
  - Redir to 0x80 while held; release stall_i → first request address 0x80.
- Wrap: RESET_VEC=0xFFFF_FFFC, ack every cycle → addresses 0xFFFF_FFFC then 0x0; link_o at first = 0x0.
- Misalign, macro defined: redir target 0x102 in HOLD → misalign_o=1 for one cycle, pc=0x180.
- Misalign, macro undefined: same stimulus → pc=0x100, misalign_o=0.
